// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator: drives instruction_memory, absorbs its 1-cycle read latency
// with a 2-entry buffer, and handles redirects. Optional fault path: IFETCH_MISALIGN_CHECK_EN.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_instr,
    output logic [31:0]       if_pc,
    output logic              if_misaligned
);
    localparam int          DEPTH       = 2;
    localparam logic [31:0] FAULT_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
        logic        fault;
`endif
    } entry_t;

    logic [31:0] fetch_pc_reg, fetch_pc_next;
    logic        inflight_reg, inflight_next;
    logic [31:0] inflight_pc_reg, inflight_pc_next;
    entry_t      ent_reg  [DEPTH];
    entry_t      ent_next [DEPTH];
    entry_t      cap_entry;
    logic [1:0]  occupancy;
    logic        pop;
    logic        room;
    logic        issue;
`ifdef IFETCH_MISALIGN_CHECK_EN
    logic        halted_reg, halted_next;
    logic        misaligned_redirect;
    entry_t      fault_entry;
`endif

    assign imem_addr = fetch_pc_reg[ADDR_W+1:2];
    assign if_valid  = ent_reg[0].valid;
    assign if_instr  = ent_reg[0].instr;
    assign if_pc     = ent_reg[0].pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
    assign if_misaligned = ent_reg[0].fault;
`else
    assign if_misaligned = 1'b0;
`endif

    // Occupancy counts the in-flight read, so the buffer can never overflow when it lands.
    always_comb begin
        occupancy = 2'(ent_reg[0].valid) + 2'(ent_reg[1].valid) + 2'(inflight_reg);
        pop       = ent_reg[0].valid && if_ready;
        room      = (occupancy - 2'(pop)) < 2'd2;
`ifdef IFETCH_MISALIGN_CHECK_EN
        issue     = !redirect_valid && !halted_reg && room;
`else
        issue     = !redirect_valid && room;
`endif
    end

    always_comb begin
        cap_entry       = '0;
        cap_entry.valid = 1'b1;
        cap_entry.instr = imem_rdata;
        cap_entry.pc    = inflight_pc_reg;
        for (int i = 0; i < DEPTH; i++) begin
            ent_next[i] = ent_reg[i];
        end
        if (pop) begin
            ent_next[0] = ent_reg[1];
            ent_next[1] = '0;
        end
        if (inflight_reg) begin
            if (!ent_next[0].valid) begin
                ent_next[0] = cap_entry;
            end else begin
                ent_next[1] = cap_entry;
            end
        end
`ifdef IFETCH_MISALIGN_CHECK_EN
        misaligned_redirect = redirect_pc[1:0] != 2'b00;
        fault_entry         = '0;
        fault_entry.valid   = 1'b1;
        fault_entry.instr   = FAULT_INSTR;
        fault_entry.pc      = redirect_pc;
        fault_entry.fault   = 1'b1;
`endif
        if (redirect_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_next[i] = '0;
            end
`ifdef IFETCH_MISALIGN_CHECK_EN
            if (misaligned_redirect) begin
                ent_next[0] = fault_entry;
            end
`endif
        end
    end

    // Any pending read is either captured this edge or squashed, so inflight follows issue.
    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        inflight_next    = issue;
        inflight_pc_next = inflight_pc_reg;
`ifdef IFETCH_MISALIGN_CHECK_EN
        halted_next      = halted_reg;
`endif
        if (redirect_valid) begin
`ifdef IFETCH_MISALIGN_CHECK_EN
            fetch_pc_next = redirect_pc;
            halted_next   = misaligned_redirect;
`else
            fetch_pc_next = redirect_pc & ~32'h0000_0003;
`endif
        end else if (issue) begin
            inflight_pc_next = fetch_pc_reg;
            fetch_pc_next    = fetch_pc_reg + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg    <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
`ifdef IFETCH_MISALIGN_CHECK_EN
            halted_reg      <= 1'b0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg[i] <= '0;
            end
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            inflight_reg    <= inflight_next;
            inflight_pc_reg <= inflight_pc_next;
`ifdef IFETCH_MISALIGN_CHECK_EN
            halted_reg      <= halted_next;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg[i] <= ent_next[i];
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a behavioural instruction_memory (word i holds i).
`timescale 1ns/1ps
module tb_ifetch_unit;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              if_valid;
    logic              if_ready;
    logic [31:0]       if_instr;
    logic [31:0]       if_pc;
    logic              if_misaligned;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [1 << ADDR_W];

    ifetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .if_misaligned(if_misaligned)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = i;
    end

    always @(posedge clk) imem_rdata <= mem[imem_addr];

    always @(posedge clk) begin
        if (rst_n && if_valid && if_ready)
            $display("xfer pc=%08h instr=%08h misaligned=%0b", if_pc, if_instr, if_misaligned);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", if_valid); end
        checks++;
        if (if_instr !== 32'd0) begin errors++; $display("FAIL reset_instr got=%h exp=0", if_instr); end
        checks++;
        if (if_pc !== 32'd0) begin errors++; $display("FAIL reset_pc got=%h exp=0", if_pc); end
        checks++;
        if (if_misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis got=%0b exp=0", if_misaligned); end
        checks++;
        if (imem_addr !== 10'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", imem_addr); end
        checks++;
    endtask

    task automatic test_startup_stream();
        @(negedge clk);
        rst_n = 1'b1; if_ready = 1'b1;
        step();  // E0
        if (if_valid !== 1'b0) begin errors++; $display("FAIL e0_valid got=%0b exp=0", if_valid); end
        checks++;
        if (imem_addr !== 10'd1) begin errors++; $display("FAIL e0_addr got=%0d exp=1", imem_addr); end
        checks++;
        step();  // E1
        if (if_valid !== 1'b1 || if_pc !== 32'd0 || if_instr !== 32'd0) begin
            errors++; $display("FAIL e1_head got v=%0b pc=%h instr=%h exp v=1 pc=0 instr=0", if_valid, if_pc, if_instr);
        end
        checks++;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (if_valid !== 1'b1 || if_pc !== 32'(4 * k) || if_instr !== 32'(k)) begin
                errors++; $display("FAIL stream_%0d got v=%0b pc=%h instr=%h exp pc=%h instr=%h",
                                   k, if_valid, if_pc, if_instr, 32'(4 * k), 32'(k));
            end
            checks++;
        end
    endtask

    task automatic test_backpressure();
        if_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (if_valid !== 1'b1 || if_pc !== 32'd20 || if_instr !== 32'd5) begin
                errors++; $display("FAIL stall_hold_%0d got v=%0b pc=%h instr=%h exp pc=14 instr=5",
                                   k, if_valid, if_pc, if_instr);
            end
            checks++;
            if (imem_addr !== 10'd7) begin errors++; $display("FAIL stall_addr_%0d got=%0d exp=7", k, imem_addr); end
            checks++;
        end
        if_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (if_valid !== 1'b1 || if_pc !== 32'(20 + 4 * k) || if_instr !== 32'(5 + k)) begin
                errors++; $display("FAIL resume_%0d got v=%0b pc=%h instr=%h exp pc=%h instr=%h",
                                   k, if_valid, if_pc, if_instr, 32'(20 + 4 * k), 32'(5 + k));
            end
            checks++;
        end
    endtask

    task automatic test_redirect();
        if_ready = 1'b0;
        step();
        step();
        if (if_pc !== 32'd36) begin errors++; $display("FAIL pre_redirect_pc got=%h exp=24", if_pc); end
        checks++;
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();  // N
        redirect_valid = 1'b0; if_ready = 1'b1;
        if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_n_valid got=%0b exp=0", if_valid); end
        checks++;
        if (imem_addr !== 10'h10) begin errors++; $display("FAIL redir_addr got=%0d exp=16", imem_addr); end
        checks++;
        step();  // N+1
        if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_n1_valid got=%0b exp=0", if_valid); end
        checks++;
        step();  // N+2
        if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== 32'd16) begin
            errors++; $display("FAIL redir_target got v=%0b pc=%h instr=%h exp pc=40 instr=10", if_valid, if_pc, if_instr);
        end
        checks++;
        step();
        if (if_pc !== 32'h44 || if_instr !== 32'd17) begin
            errors++; $display("FAIL redir_next got pc=%h instr=%h exp pc=44 instr=11", if_pc, if_instr);
        end
        checks++;
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFF8;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        if (if_pc !== 32'hFF8 || if_instr !== 32'd1022) begin
            errors++; $display("FAIL wrap_ff8 got pc=%h instr=%h exp pc=ff8 instr=3fe", if_pc, if_instr);
        end
        checks++;
        if (imem_addr !== 10'd0) begin errors++; $display("FAIL wrap_addr got=%0d exp=0", imem_addr); end
        checks++;
        step();
        if (if_pc !== 32'hFFC || if_instr !== 32'd1023) begin
            errors++; $display("FAIL wrap_ffc got pc=%h instr=%h exp pc=ffc instr=3ff", if_pc, if_instr);
        end
        checks++;
        step();
        if (if_pc !== 32'h1000 || if_instr !== 32'd0) begin
            errors++; $display("FAIL wrap_1000 got pc=%h instr=%h exp pc=1000 instr=0", if_pc, if_instr);
        end
        checks++;
        step();
        if (if_pc !== 32'h1004 || if_instr !== 32'd1) begin
            errors++; $display("FAIL wrap_1004 got pc=%h instr=%h exp pc=1004 instr=1", if_pc, if_instr);
        end
        checks++;
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        step();
        redirect_valid = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
        if (if_valid !== 1'b1 || if_pc !== 32'h42 || if_instr !== 32'h13 || if_misaligned !== 1'b1) begin
            errors++; $display("FAIL mis_entry got v=%0b pc=%h instr=%h mis=%0b exp v=1 pc=42 instr=13 mis=1",
                               if_valid, if_pc, if_instr, if_misaligned);
        end
        checks++;
        for (int k = 0; k < 4; k++) begin
            step();
            if (if_valid !== 1'b0) begin errors++; $display("FAIL mis_halt_%0d got=%0b exp=0", k, if_valid); end
            checks++;
        end
`else
        if (if_valid !== 1'b0) begin errors++; $display("FAIL mis_n_valid got=%0b exp=0", if_valid); end
        checks++;
        step();
        step();
        if (if_pc !== 32'h40 || if_instr !== 32'd16 || if_misaligned !== 1'b0) begin
            errors++; $display("FAIL mis_aligned got pc=%h instr=%h mis=%0b exp pc=40 instr=10 mis=0",
                               if_pc, if_instr, if_misaligned);
        end
        checks++;
`endif
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        step();
        redirect_valid = 1'b0;
        if (if_valid !== 1'b0) begin errors++; $display("FAIL resume80_n got=%0b exp=0", if_valid); end
        checks++;
        step();
        step();
        if (if_valid !== 1'b1 || if_pc !== 32'h80 || if_instr !== 32'd32 || if_misaligned !== 1'b0) begin
            errors++; $display("FAIL resume80 got v=%0b pc=%h instr=%h mis=%0b exp v=1 pc=80 instr=20 mis=0",
                               if_valid, if_pc, if_instr, if_misaligned);
        end
        checks++;
        step();
        if (if_pc !== 32'h84 || if_instr !== 32'd33) begin
            errors++; $display("FAIL resume84 got pc=%h instr=%h exp pc=84 instr=21", if_pc, if_instr);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        if (if_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_valid got=%0b exp=1", if_valid); end
        checks++;
        #3;
        rst_n = 1'b0;
        #1;
        if (if_valid !== 1'b0 || if_pc !== 32'd0 || if_instr !== 32'd0 || if_misaligned !== 1'b0) begin
            errors++; $display("FAIL rst_mid_outs got v=%0b pc=%h instr=%h mis=%0b exp all 0",
                               if_valid, if_pc, if_instr, if_misaligned);
        end
        checks++;
        if (imem_addr !== 10'd0) begin errors++; $display("FAIL rst_mid_addr got=%0d exp=0", imem_addr); end
        checks++;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step();  // E0
        if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_e0_valid got=%0b exp=0", if_valid); end
        checks++;
        step();  // E1
        if (if_valid !== 1'b1 || if_pc !== 32'd0 || if_instr !== 32'd0) begin
            errors++; $display("FAIL rst_e1_head got v=%0b pc=%h instr=%h exp v=1 pc=0 instr=0", if_valid, if_pc, if_instr);
        end
        checks++;
        step();
        if (if_pc !== 32'd4 || if_instr !== 32'd1) begin
            errors++; $display("FAIL rst_e2_head got pc=%h instr=%h exp pc=4 instr=1", if_pc, if_instr);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_startup_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_misaligned();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
